monolith_axis_ingress: RTL and testbench

MONOLITH_AXIS_INGRESS -- requirements
Module: monolith_axis_ingress

---
 rtl/monolith_axis_ingress.sv | 147 ++++++++++++++
 tb/tb_monolith_axis_ingress.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monolith_axis_ingress.sv
// AXI-Stream ingress for a mod-(2^31-1) hash core.
// Accepts 32-bit words, reduces each into the Mersenne-31 field, and packs
// WORDS of them into one state block. Short messages are padded out to a full
// block, and the finished block is held until the hash core takes it.
module monolith_axis_ingress #(
    parameter int          WORDS     = 16,
    parameter logic [30:0] PAD_VALUE = 31'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [31*WORDS-1:0]   state_out,
    output logic                  state_valid,
    input  logic                  state_ready,
    output logic                  state_last
);

    localparam int          ELEM_W   = 31;
    localparam int          IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [31:0] P_MOD    = 32'h7FFF_FFFF;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [ELEM_W-1:0]   slots [WORDS];
    logic                accept;
    logic                at_last_slot;

    // Fold bit 31 back in (2^31 == 1 mod p), then one conditional subtract.
    // The folded sum is at most 2^31, so one subtraction always lands in 0..p-1.
    function automatic logic [ELEM_W-1:0] reduce_p(input logic [31:0] d);
        logic [31:0] s;
        s = {1'b0, d[30:0]} + {31'd0, d[31]};
        if (s >= P_MOD) begin
            s = s - P_MOD;
        end
        return s[ELEM_W-1:0];
    endfunction

    assign accept        = (state == FILL) && s_axis_tvalid;
    assign at_last_slot  = (idx == LAST_IDX);

    // Both handshake outputs decode the state register only, so neither
    // tvalid nor state_ready can reach them combinationally.
    assign s_axis_tready = (state == FILL);
    assign state_valid   = (state == HOLD);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: close a block on the last slot or on tlast
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (accept && at_last_slot) begin
                    state_nxt = HOLD;
                end else if (accept && s_axis_tlast) begin
                    state_nxt = PAD;
                end
            end
            PAD: begin
                if (at_last_slot) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (state_ready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Slot index and block-ends-message flag
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            state_last <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (at_last_slot) begin
                            idx        <= '0;
                            state_last <= s_axis_tlast;
                        end else begin
                            // On tlast idx now points at the first slot PAD fills.
                            idx <= idx + 1'b1;
                            if (s_axis_tlast) begin
                                state_last <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    if (at_last_slot) begin
                        idx <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                HOLD: begin
                    if (state_ready) begin
                        state_last <= 1'b0;
                    end
                end
                default: idx <= '0;
            endcase
        end
    end

    // Slot storage: reduced words while filling, pad value while padding
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                slots[i] <= '0;
            end
        end else if (accept) begin
            slots[idx] <= reduce_p(s_axis_tdata);
        end else if (state == PAD) begin
            slots[idx] <= PAD_VALUE;
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : g_pack
        assign state_out[ELEM_W*g +: ELEM_W] = slots[g];
    end

endmodule

// File: tb/tb_monolith_axis_ingress.sv
// Bench for monolith_axis_ingress: a transaction-level model predicts which
// cycles offer a block and what that block holds, and the directed tests pin
// the model with hand-computed block contents and latencies.
module tb_monolith_axis_ingress;

    localparam int          WORDS = 16;
    localparam logic [30:0] PADV  = 31'd0;
    localparam int          VW    = 31 * WORDS;

    logic            clk;
    logic            reset;
    logic [31:0]     s_axis_tdata;
    logic            s_axis_tvalid;
    logic            s_axis_tready;
    logic            s_axis_tlast;
    logic [VW-1:0]   state_out;
    logic            state_valid;
    logic            state_ready;
    logic            state_last;

    monolith_axis_ingress #(
        .WORDS     (WORDS),
        .PAD_VALUE (PADV)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .state_out     (state_out),
        .state_valid   (state_valid),
        .state_ready   (state_ready),
        .state_last    (state_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_acc;
    int vcyc;
    int lowcnt;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s cycle %0d: bound expired", name, cyc);
    endtask

    // Field reduction stated directly as the remainder modulo 2^31-1.
    function automatic logic [30:0] mred(input logic [31:0] d);
        longint unsigned v;
        v = longint'(d);
        return 31'(v % 64'd2147483647);
    endfunction

    // ---------------- reference model and compare process ----------------
    typedef enum int { COLLECTING, CLOSING, OFFERED } phase_t;
    phase_t       phase = COLLECTING;
    logic [30:0]  mblk[$];
    logic         mlast;
    int           mready_cyc;
    bit           armed    = 0;
    bit           post_rst = 0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            armed    = 1;
            post_rst = 1;
            phase    = COLLECTING;
            mblk.delete();
        end else if (armed) begin
            if (post_rst) begin
                chk_vec("reset_state_out", state_out, '0);
                chk("reset_state_last", 64'(state_last), 64'd0);
                post_rst = 0;
            end
            if (phase == CLOSING && cyc >= mready_cyc) phase = OFFERED;
            chk("tready", 64'(s_axis_tready), 64'(phase == COLLECTING));
            chk("state_valid", 64'(state_valid), 64'(phase == OFFERED));
            if (phase == OFFERED) begin
                logic [VW-1:0] ev;
                for (int i = 0; i < WORDS; i++) ev[31*i +: 31] = mblk[i];
                chk_vec("model_state_out", state_out, ev);
                chk("model_state_last", 64'(state_last), 64'(mlast));
                if (state_ready) begin
                    phase = COLLECTING;
                    mblk.delete();
                end
            end else if (phase == COLLECTING && s_axis_tvalid) begin
                mblk.push_back(mred(s_axis_tdata));
                if (mblk.size() == WORDS || s_axis_tlast) begin
                    int k;
                    k          = mblk.size() - 1;
                    mlast      = s_axis_tlast;
                    mready_cyc = cyc + (WORDS - 1 - k) + 1;
                    while (mblk.size() < WORDS) mblk.push_back(PADV);
                    phase = CLOSING;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] d, input logic l);
        bit ok;
        ok            = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("send_accept");
        last_acc = cyc;
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the caller on the negedge where state_valid is first seen high.
    task automatic wait_valid();
        bit ok;
        ok     = 0;
        lowcnt = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (state_valid) begin
                ok = 1;
                break;
            end
            if (!s_axis_tready) lowcnt++;
        end
        if (!ok) timeout("wait_valid");
        vcyc = cyc;
    endtask

    function automatic logic [30:0] el(input int i);
        return state_out[31*i +: 31];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    logic [VW-1:0] snap;

    initial begin
        reset         = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        state_ready   = 1'b1;
        idle(3);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_tready", 64'(s_axis_tready), 64'd1);
        chk("reset_valid", 64'(state_valid), 64'd0);
        idle(1);

        // Full block 0..15, tlast on word 15, core always ready.
        for (int i = 0; i < WORDS; i++) send(32'(i), i == WORDS - 1);
        wait_valid();
        chk("full_latency", 64'(vcyc - last_acc), 64'd1);
        for (int i = 0; i < WORDS; i++) chk("full_elem", 64'(el(i)), 64'(i));
        chk("full_last", 64'(state_last), 64'd1);
        @(negedge clk);
        chk("full_single_valid", 64'(state_valid), 64'd0);
        idle(1);

        // Reduction corner values, short message padded with zeros.
        send(32'h7FFF_FFFF, 0);
        send(32'hFFFF_FFFF, 0);
        send(32'h8000_0000, 0);
        send(32'hFFFF_FFFE, 0);
        send(32'h7FFF_FFFE, 1);
        wait_valid();
        chk("red_0", 64'(el(0)), 64'h0);
        chk("red_1", 64'(el(1)), 64'h1);
        chk("red_2", 64'(el(2)), 64'h1);
        chk("red_3", 64'(el(3)), 64'h0);
        chk("red_4", 64'(el(4)), 64'h7FFF_FFFE);
        chk("red_pad", 64'(el(15)), 64'h0);
        idle(1);

        // Short message A,B,C: 13 pad cycles, valid 14 cycles after tlast.
        send(32'hA, 0);
        send(32'hB, 0);
        send(32'hC, 1);
        wait_valid();
        chk("short_latency", 64'(vcyc - last_acc), 64'd14);
        chk("short_tready_low", 64'(lowcnt), 64'd13);
        chk("short_0", 64'(el(0)), 64'hA);
        chk("short_1", 64'(el(1)), 64'hB);
        chk("short_2", 64'(el(2)), 64'hC);
        for (int i = 3; i < WORDS; i++) chk("short_pad", 64'(el(i)), 64'h0);
        chk("short_last", 64'(state_last), 64'd1);
        idle(1);

        // Backpressure: core stalls for 5 cycles with a full block offered.
        state_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) send(32'h50 + 32'(i), i == WORDS - 1);
        wait_valid();
        snap = state_out;
        chk("bp_first_elem", 64'(el(0)), 64'h50);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_held", 64'(state_valid), 64'd1);
            chk("bp_tready_low", 64'(s_axis_tready), 64'd0);
            chk_vec("bp_stable", state_out, snap);
        end
        @(posedge clk);
        #1;
        state_ready = 1'b1;
        @(negedge clk);
        chk("bp_handshake_valid", 64'(state_valid), 64'd1);
        @(negedge clk);
        chk("bp_tready_after", 64'(s_axis_tready), 64'd1);
        chk("bp_valid_after", 64'(state_valid), 64'd0);
        idle(1);

        // Reset mid-fill discards 7 words; the next 16 form a fresh block.
        for (int i = 0; i < 7; i++) send(32'h900 + 32'(i), 0);
        do_reset();
        for (int i = 0; i < WORDS; i++) send(32'd100 + 32'(i), 0);
        wait_valid();
        chk("rst_latency", 64'(vcyc - last_acc), 64'd1);
        for (int i = 0; i < WORDS; i++) chk("rst_elem", 64'(el(i)), 64'(100 + i));
        chk("rst_last", 64'(state_last), 64'd0);
        idle(1);

        // Multi-block frame of 20 words with idle gaps, tlast on word 20.
        for (int i = 1; i <= 16; i++) begin
            idle(i % 3);
            send(32'(i), 0);
        end
        wait_valid();
        for (int i = 0; i < WORDS; i++) chk("mb1_elem", 64'(el(i)), 64'(i + 1));
        chk("mb1_last", 64'(state_last), 64'd0);
        idle(1);
        for (int i = 17; i <= 20; i++) begin
            idle(i % 3);
            send(32'(i), i == 20);
        end
        wait_valid();
        for (int i = 0; i < 4; i++) chk("mb2_elem", 64'(el(i)), 64'(17 + i));
        for (int i = 4; i < WORDS; i++) chk("mb2_pad", 64'(el(i)), 64'h0);
        chk("mb2_last", 64'(state_last), 64'd1);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
